lbus_host_master: RTL
=====================

// Module: lbus_host_master
// PURPOSE
//  Initiator for the 16-bit multiplexed SASEBO local bus: address phase with lbus_wrn=1, data phase with lbus_wrn=0, read strobe lbus_rdn=0.
//  Converts single-word host commands into timed bus cycles and returns the read data and completion.
//  Sits in the control-side logic and drives the crypto FPGA's LBUS_IF, e.g. key/text loads and status/result reads.
// PARAMETERS
//  ADDR_SETUP  1      cycles address is driven (wrn=1, rdn=1) before the data or strobe phase; >=1
//  WR_PULSE    2      cycles lbus_wrn held low with write data driven; >=1
//  RD_WAIT     3      cycles lbus_rdn held low; lbus_do sampled on the last one; >=1
//  TURNAROUND  1      idle cycles (wrn=1, rdn=1) after each data/strobe phase; >=1
//  POLL_MAX    1024   max read attempts per poll command (LBUS_POLL_EN only); >=1
// PORTS
//  clk         in   1   bus clock, shared with the local bus
//  rst         in   1   synchronous, active-high reset
//  cmd_valid   in   1   command offered
//  cmd_ready   out  1   command accepted when cmd_valid & cmd_ready
//  cmd_write   in   1   1=write, 0=read
//  cmd_addr    in   16  bus address
//  cmd_wdata   in   16  write data; poll compare value under LBUS_POLL_EN
//  cmd_poll    in   1   LBUS_POLL_EN only: poll-read command (cmd_write ignored)
//  cmd_mask    in   16  LBUS_POLL_EN only: poll compare mask
//  rsp_valid   out  1   one-cycle completion pulse; no backpressure
//  rsp_rdata   out  16  read data; 0 for writes; held until next rsp
//  rsp_timeout out  1   poll exhausted POLL_MAX (0 otherwise), valid with rsp_valid
//  busy        out  1   command in progress (not IDLE)
//  lbus_di_a   out  16  multiplexed address/write data
//  lbus_wrn    out  1   1=address phase, 0=data phase
//  lbus_rdn    out  1   active-low read strobe
//  lbus_do     in   16  read data from responder
// BEHAVIOUR
//  Reset values: lbus_wrn=1, lbus_rdn=1, lbus_di_a=0, cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_timeout=0, busy=0.
//  rst asserted mid-command: next edge forces IDLE and wrn=rdn=1; no rsp_valid for the aborted command.
//  FSM: IDLE -> ADDR -> (WDATA | RSTB) -> TURN -> RSP -> IDLE. Under LBUS_POLL_EN, TURN loops back to ADDR while polling.
//  IDLE: cmd_ready=1. Acceptance at cycle 0 latches cmd_* and drops cmd_ready starting at cycle 1.
//  ADDR: cycles 1..ADDR_SETUP; lbus_di_a=addr, wrn=1, rdn=1.
//  WDATA: next WR_PULSE cycles; lbus_di_a=wdata, wrn=0.
//  RSTB: next RD_WAIT cycles; lbus_di_a=addr, rdn=0; lbus_do registered on the last rdn=0 cycle.
//  TURN: TURNAROUND cycles; wrn=1, rdn=1, lbus_di_a holds its previous value.
//  RSP: one cycle; rsp_valid=1, cmd_ready=0; IDLE follows.
//  Latency with defaults: write rsp at cycle 5, read rsp at cycle 6; next acceptance is possible one cycle after rsp.
//  wrn and rdn are never low in the same cycle; no bus transition happens outside these phases.
//  One phase down-counter sized for max(ADDR_SETUP, WR_PULSE, RD_WAIT, TURNAROUND); it reloads on every state entry.
// CONFIGURATION
//  LBUS_POLL_EN defined: cmd_poll and cmd_mask ports exist, and cmd_poll=1 runs repeated reads of cmd_addr.
//    Match condition: (rdata & mask) == (wdata & mask). On match: RSP, rsp_timeout=0, rsp_rdata=matching word.
//    No match: TURN is followed by ADDR again. The attempt counter is 1-based.
//    Attempt POLL_MAX with no match: RSP, rsp_timeout=1, rsp_rdata=last read.
//    POLL_MAX=1 behaves as a single read with compare.
//  LBUS_POLL_EN undefined: no poll ports or counter; rsp_timeout tied 0.
// STRUCTURE
//  Package lbus_host_pkg: LBUS_AW/LBUS_DW=16, state enum, default timing constants.
//  Sub-module lbus_phase_timer: loadable down-counter with a done flag.
// TESTING
//  Reset: rst=1 for 3 cycles -> wrn=rdn=1, lbus_di_a=0, cmd_ready=0; cmd_ready=1 one cycle after rst falls.
//  Write 0x0002<=0x0001 -> 1 cycle di_a=0x0002 wrn=1; 2 cycles di_a=0x0001 wrn=0; rsp_valid at cycle 5, rsp_rdata=0.
//  Read 0x0180 with responder driving 0xBEEF -> rdn low cycles 2-4; rsp_valid at cycle 6 with rsp_rdata=0xBEEF.
//  Back-to-back write then read held on cmd_valid -> second accepted at cycle 6; wrn and rdn never low together.
//  Reset at cycle 2 of a write (wrn=0) -> next cycle wrn=1, IDLE, no rsp_valid.
//  LBUS_POLL_EN: poll addr 0x0002, mask 0x0001, val 0x0000, responder returns 0x0001 x3 then 0x0000 -> rsp_timeout=0, rdata=0x0000, 4 strobes.
//  LBUS_POLL_EN: POLL_MAX=4, responder stuck at 0x0001 -> exactly 4 strobes, rsp_timeout=1, rsp_rdata=0x0001.

Source files
------------

// File: rtl/lbus_host_pkg.sv
// Shared widths, FSM state encoding and default timing for the local-bus host master.
package lbus_host_pkg;

    localparam int LBUS_AW = 16;
    localparam int LBUS_DW = 16;

    localparam int DEF_ADDR_SETUP = 1;
    localparam int DEF_WR_PULSE   = 2;
    localparam int DEF_RD_WAIT    = 3;
    localparam int DEF_TURNAROUND = 1;
    localparam int DEF_POLL_MAX   = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WDATA,
        ST_RSTB,
        ST_TURN,
        ST_RSP
    } state_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lbus_host_master_if.sv
// Host command/response and local-bus pins of the host master; poll fields exist only with LBUS_POLL_EN.
interface lbus_host_master_if;
    import lbus_host_pkg::*;

    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_write;
    logic [LBUS_AW-1:0] cmd_addr;
    logic [LBUS_DW-1:0] cmd_wdata;
`ifdef LBUS_POLL_EN
    logic               cmd_poll;
    logic [LBUS_DW-1:0] cmd_mask;
`endif
    logic               rsp_valid;
    logic [LBUS_DW-1:0] rsp_rdata;
    logic               rsp_timeout;
    logic               busy;
    logic [LBUS_AW-1:0] lbus_di_a;
    logic               lbus_wrn;
    logic               lbus_rdn;
    logic [LBUS_DW-1:0] lbus_do;

    modport master (
`ifdef LBUS_POLL_EN
        input  cmd_poll, cmd_mask,
`endif
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, lbus_do,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout, busy,
        output lbus_di_a, lbus_wrn, lbus_rdn
    );

    modport slave (
`ifdef LBUS_POLL_EN
        output cmd_poll, cmd_mask,
`endif
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, lbus_do,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout, busy,
        input  lbus_di_a, lbus_wrn, lbus_rdn
    );

endinterface

// File: rtl/lbus_phase_timer.sv
// Loadable phase down-counter: load N-1 on state entry, done_o is high on the phase's last cycle.
module lbus_phase_timer #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    output logic          done_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/lbus_host_master.sv
// Local-bus initiator: one host command -> timed ADDR/WDATA|RSTB/TURN cycle, one-cycle rsp pulse (write rsp cycle 5, read cycle 6 at defaults).
// Accepts a new command only in IDLE; the response has no backpressure. LBUS_POLL_EN adds repeated-read polling.
module lbus_host_master
    import lbus_host_pkg::*;
#(
    parameter int ADDR_SETUP = DEF_ADDR_SETUP,
    parameter int WR_PULSE   = DEF_WR_PULSE,
    parameter int RD_WAIT    = DEF_RD_WAIT,
    parameter int TURNAROUND = DEF_TURNAROUND
`ifdef LBUS_POLL_EN
  , parameter int POLL_MAX   = DEF_POLL_MAX
`endif
) (
    input  logic               clk,
    input  logic               rst,
    lbus_host_master_if.master bus
);

    localparam int TMAX = max4(ADDR_SETUP, WR_PULSE, RD_WAIT, TURNAROUND);
    localparam int CW   = cnt_width(TMAX);

    state_t             state_q;
    logic               wr_q;
    logic [LBUS_AW-1:0] addr_q;
    logic [LBUS_DW-1:0] wdata_q;
    logic [LBUS_DW-1:0] rd_q;
    logic [LBUS_AW-1:0] di_a_q;
    logic               wrn_q, rdn_q;
    logic               ready_q, busy_q;
    logic               rsp_valid_q;
    logic [LBUS_DW-1:0] rsp_rdata_q;

    logic               accept;
    logic               tmr_load, tmr_done;
    logic [CW-1:0]      tmr_val;
    logic               poll_again;

    assign accept = bus.cmd_valid & ready_q;

`ifdef LBUS_POLL_EN
    localparam int AW_ATT = cnt_width(POLL_MAX + 1);
    logic               poll_q;
    logic [LBUS_DW-1:0] mask_q;
    logic [AW_ATT-1:0]  att_q;
    logic               rsp_to_q;
    logic               poll_hit;

    assign poll_hit   = (((rd_q ^ wdata_q) & mask_q) == '0);
    assign poll_again = poll_q & ~poll_hit & (att_q != AW_ATT'(POLL_MAX));
`else
    assign poll_again = 1'b0;
`endif

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_IDLE: begin
                tmr_load = accept;
                tmr_val  = CW'(ADDR_SETUP - 1);
            end
            ST_ADDR: begin
                tmr_load = tmr_done;
                tmr_val  = wr_q ? CW'(WR_PULSE - 1) : CW'(RD_WAIT - 1);
            end
            ST_WDATA, ST_RSTB: begin
                tmr_load = tmr_done;
                tmr_val  = CW'(TURNAROUND - 1);
            end
            ST_TURN: begin
                tmr_load = tmr_done;
                tmr_val  = CW'(ADDR_SETUP - 1);
            end
            default: ;
        endcase
    end

    lbus_phase_timer #(.CW(CW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_q        <= '0;
            di_a_q      <= '0;
            wrn_q       <= 1'b1;
            rdn_q       <= 1'b1;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef LBUS_POLL_EN
            poll_q      <= 1'b0;
            mask_q      <= '0;
            att_q       <= '0;
            rsp_to_q    <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_ADDR;
                        addr_q  <= bus.cmd_addr;
                        wdata_q <= bus.cmd_wdata;
                        di_a_q  <= bus.cmd_addr;
`ifdef LBUS_POLL_EN
                        wr_q    <= bus.cmd_write & ~bus.cmd_poll;
                        poll_q  <= bus.cmd_poll;
                        mask_q  <= bus.cmd_mask;
                        att_q   <= AW_ATT'(1);
`else
                        wr_q    <= bus.cmd_write;
`endif
                    end
                end
                ST_ADDR: begin
                    if (tmr_done) begin
                        if (wr_q) begin
                            state_q <= ST_WDATA;
                            di_a_q  <= wdata_q;
                            wrn_q   <= 1'b0;
                        end else begin
                            state_q <= ST_RSTB;
                            rdn_q   <= 1'b0;
                        end
                    end
                end
                ST_WDATA: begin
                    if (tmr_done) begin
                        state_q <= ST_TURN;
                        wrn_q   <= 1'b1;
                    end
                end
                ST_RSTB: begin
                    if (tmr_done) begin
                        state_q <= ST_TURN;
                        rdn_q   <= 1'b1;
                        rd_q    <= bus.lbus_do;
                    end
                end
                ST_TURN: begin
                    if (tmr_done) begin
                        if (poll_again) begin
                            state_q <= ST_ADDR;
                            di_a_q  <= addr_q;
`ifdef LBUS_POLL_EN
                            att_q   <= att_q + AW_ATT'(1);
`endif
                        end else begin
                            state_q     <= ST_RSP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= wr_q ? '0 : rd_q;
`ifdef LBUS_POLL_EN
                            rsp_to_q    <= poll_q & ~poll_hit;
`endif
                        end
                    end
                end
                ST_RSP: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.busy      = busy_q;
    assign bus.lbus_di_a = di_a_q;
    assign bus.lbus_wrn  = wrn_q;
    assign bus.lbus_rdn  = rdn_q;
`ifdef LBUS_POLL_EN
    assign bus.rsp_timeout = rsp_to_q;
`else
    assign bus.rsp_timeout = 1'b0;
`endif

endmodule
